// File: rtl/kte_pkg.sv
// Shared definitions for the keypad time-entry block: key codes, scanner
// states, BCD buffer slot indices and the keypad map.
package kte_pkg;

    localparam int unsigned KEY_W      = 4;
    localparam int unsigned PTR_W      = 3;
    localparam int unsigned LINE_W     = 4;
    localparam int unsigned NUM_SLOTS  = 6;
    localparam int unsigned DIGITS_HMS = 6;
    localparam int unsigned DIGITS_MS  = 4;

    localparam logic [KEY_W-1:0] KEY_A    = 4'd10;
    localparam logic [KEY_W-1:0] KEY_B    = 4'd11;
    localparam logic [KEY_W-1:0] KEY_C    = 4'd12;
    localparam logic [KEY_W-1:0] KEY_D    = 4'd13;
    localparam logic [KEY_W-1:0] KEY_STAR = 4'd14;
    localparam logic [KEY_W-1:0] KEY_HASH = 4'd15;
    localparam logic [KEY_W-1:0] KEY_MAX_DIGIT = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } scan_state_e;

    localparam logic [PTR_W-1:0] SLOT_H1 = 3'd0;
    localparam logic [PTR_W-1:0] SLOT_H0 = 3'd1;
    localparam logic [PTR_W-1:0] SLOT_M1 = 3'd2;
    localparam logic [PTR_W-1:0] SLOT_M0 = 3'd3;
    localparam logic [PTR_W-1:0] SLOT_S1 = 3'd4;
    localparam logic [PTR_W-1:0] SLOT_S0 = 3'd5;

    // Lowest-index active-low row wins when several rows are pulled low.
    function automatic logic [1:0] lowest_row(input logic [LINE_W-1:0] r);
        logic [1:0] idx;
        if (!r[0])      idx = 2'd0;
        else if (!r[1]) idx = 2'd1;
        else if (!r[2]) idx = 2'd2;
        else            idx = 2'd3;
        return idx;
    endfunction

    function automatic logic [KEY_W-1:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        logic [KEY_W-1:0] code;
        case ({r, c})
            4'b00_00: code = 4'd1;
            4'b00_01: code = 4'd2;
            4'b00_10: code = 4'd3;
            4'b00_11: code = KEY_A;
            4'b01_00: code = 4'd4;
            4'b01_01: code = 4'd5;
            4'b01_10: code = 4'd6;
            4'b01_11: code = KEY_B;
            4'b10_00: code = 4'd7;
            4'b10_01: code = 4'd8;
            4'b10_10: code = 4'd9;
            4'b10_11: code = KEY_C;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = 4'd0;
            4'b11_10: code = KEY_HASH;
            default:  code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner with row synchroniser and slot-based press/release debounce;
// emits one event per accepted press.
module keypad_scanner
    import kte_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned DEB_SLOTS = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [LINE_W-1:0] row,
    output logic [LINE_W-1:0] col,
    output logic              key_valid,
    output logic [KEY_W-1:0]  key_code,
    output logic              key_hit_c,
    output logic [KEY_W-1:0]  key_hit_code_c
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DEB_W = (DEB_SLOTS > 1) ? $clog2(DEB_SLOTS + 1) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_SLOTS - 1);

    scan_state_e       state_q, state_d;
    logic [LINE_W-1:0] row_m_q, row_s_q;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [LINE_W-1:0] pat_q, pat_d;
    logic [DEB_W-1:0]  cnt_q, cnt_d;
    logic [KEY_W-1:0]  code_q, code_d;
    logic [LINE_W-1:0] col_q, col_d;
    logic              key_valid_q;
    logic [KEY_W-1:0]  key_code_q;
    logic              sample;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_m_q     <= '1;
            row_s_q     <= '1;
            div_q       <= '0;
            col_idx_q   <= '0;
            pat_q       <= '1;
            cnt_q       <= '0;
            code_q      <= '0;
            col_q       <= '1;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            row_m_q     <= row;
            row_s_q     <= row_m_q;
            div_q       <= div_d;
            col_idx_q   <= col_idx_d;
            pat_q       <= pat_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            col_q       <= col_d;
            key_valid_q <= key_hit_c;
            if (key_hit_c) key_code_q <= key_hit_code_c;
        end
    end

    // Row is only examined on the last cycle of each column slot.
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        pat_d     = pat_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        key_hit_c = 1'b0;
        sample    = (div_q == DIV_LAST);
        div_d     = sample ? '0 : div_q + DIV_W'(1);

        case (state_q)
            ST_IDLE: begin
                div_d = '0;
                if (en) begin
                    state_d   = ST_SCAN;
                    col_idx_d = 2'd0;
                end
            end
            ST_SCAN: begin
                if (sample) begin
                    if (row_s_q != '1) begin
                        pat_d  = row_s_q;
                        code_d = key_lookup(lowest_row(row_s_q), col_idx_q);
                        if (DEB_SLOTS <= 1) begin
                            state_d   = ST_HELD;
                            key_hit_c = 1'b1;
                            cnt_d     = '0;
                        end else begin
                            state_d = ST_DEBOUNCE;
                            cnt_d   = DEB_W'(1);
                        end
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (sample) begin
                    if (row_s_q == pat_q) begin
                        if (cnt_q == DEB_LAST) begin
                            state_d   = ST_HELD;
                            key_hit_c = 1'b1;
                            cnt_d     = '0;
                        end else begin
                            cnt_d = cnt_q + DEB_W'(1);
                        end
                    end else begin
                        state_d   = ST_SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
            end
            ST_HELD: begin
                if (sample) begin
                    if (row_s_q == '1) begin
                        if (cnt_q == DEB_LAST) begin
                            state_d = ST_RELEASE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + DEB_W'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            ST_RELEASE: begin
                state_d   = ST_SCAN;
                col_idx_d = col_idx_q + 2'd1;
                div_d     = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        if (!en) begin
            state_d   = ST_IDLE;
            div_d     = '0;
            key_hit_c = 1'b0;
        end

        col_d          = (state_d == ST_IDLE) ? '1 : ~(LINE_W'(1) << col_idx_d);
        key_hit_code_c = code_d;
    end

    assign col       = col_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;

endmodule

// File: rtl/keypad_time_entry.sv
// Keypad time entry: scanner events drive a validated BCD hh:mm:ss / mm:ss
// buffer with clear (*) and backspace (#).
module keypad_time_entry
    import kte_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned DEB_SLOTS = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic [LINE_W-1:0] row,
    output logic [LINE_W-1:0] col,
    output logic [KEY_W-1:0]  h1,
    output logic [KEY_W-1:0]  h0,
    output logic [KEY_W-1:0]  m1,
    output logic [KEY_W-1:0]  m0,
    output logic [KEY_W-1:0]  s1,
    output logic [KEY_W-1:0]  s0,
    output logic              key_valid,
    output logic [KEY_W-1:0]  key_code,
    output logic              key_err,
    output logic [PTR_W-1:0]  digit_ptr,
    output logic              done
);

    logic              hit;
    logic [KEY_W-1:0]  hit_code;
    logic [KEY_W-1:0]  dig_q [NUM_SLOTS];
    logic [KEY_W-1:0]  dig_d [NUM_SLOTS];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              en_q, mode_q;
    logic              clr;
    logic              full;
    logic [PTR_W-1:0]  n_dig, base, slot, prev_slot;
    logic [KEY_W-1:0]  limit;

    keypad_scanner #(
        .SCAN_DIV  (SCAN_DIV),
        .DEB_SLOTS (DEB_SLOTS)
    ) u_scan (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .row            (row),
        .col            (col),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .key_hit_c      (hit),
        .key_hit_code_c (hit_code)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) dig_q[i] <= '0;
            ptr_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            en_q   <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            dig_q  <= dig_d;
            ptr_q  <= ptr_d;
            done_q <= done_d;
            err_q  <= err_d;
            en_q   <= en;
            mode_q <= mode;
        end
    end

    // mm:ss entry uses the upper four slots, so the write slot is offset by two.
    always_comb begin
        dig_d     = dig_q;
        ptr_d     = ptr_q;
        err_d     = 1'b0;
        clr       = (en && !en_q) || (mode != mode_q);
        n_dig     = mode ? PTR_W'(DIGITS_HMS) : PTR_W'(DIGITS_MS);
        base      = mode ? SLOT_H1 : SLOT_M1;
        slot      = base + ptr_q;
        prev_slot = slot - PTR_W'(1);
        full      = (ptr_q == n_dig);

        case (slot)
            SLOT_H1:          limit = 4'd2;
            SLOT_H0:          limit = (dig_q[SLOT_H1] == 4'd2) ? 4'd3 : 4'd9;
            SLOT_M1, SLOT_S1: limit = 4'd5;
            default:          limit = 4'd9;
        endcase

        if (clr) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) dig_d[i] = '0;
            ptr_d = '0;
        end else if (hit) begin
            if (hit_code <= KEY_MAX_DIGIT) begin
                if (full || (hit_code > limit)) begin
                    err_d = 1'b1;
                end else begin
                    for (int unsigned i = 0; i < NUM_SLOTS; i++)
                        if (PTR_W'(i) == slot) dig_d[i] = hit_code;
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end else if (hit_code == KEY_STAR) begin
                for (int unsigned i = 0; i < NUM_SLOTS; i++) dig_d[i] = '0;
                ptr_d = '0;
            end else if ((hit_code == KEY_HASH) && (ptr_q != '0)) begin
                for (int unsigned i = 0; i < NUM_SLOTS; i++)
                    if (PTR_W'(i) == prev_slot) dig_d[i] = '0;
                ptr_d = ptr_q - PTR_W'(1);
            end
        end

        done_d = (ptr_d == n_dig);
    end

    assign h1        = dig_q[SLOT_H1];
    assign h0        = dig_q[SLOT_H0];
    assign m1        = dig_q[SLOT_M1];
    assign m0        = dig_q[SLOT_M0];
    assign s1        = dig_q[SLOT_S1];
    assign s0        = dig_q[SLOT_S0];
    assign digit_ptr = ptr_q;
    assign done      = done_q;
    assign key_err   = err_q;

endmodule

// File: tb/tb_keypad_time_entry.sv
// Directed bench for keypad_time_entry: a keypad model driven from a table of
// key presses with expected buffer state, plus multi-cycle corner sequences.
module tb_keypad_time_entry;

    localparam int unsigned SCAN_DIV  = 4;
    localparam int unsigned DEB_SLOTS = 2;
    localparam int NV = 34;

    logic       clk = 1'b0;
    logic       rst, en, mode;
    logic [3:0] row, col;
    logic [3:0] h1, h0, m1, m0, s1, s0;
    logic       key_valid, key_err, done;
    logic [3:0] key_code;
    logic [2:0] digit_ptr;

    logic       kp_on, force_on;
    logic [1:0] kp_r, kp_c;
    logic [3:0] force_val;

    int n_chk = 0;
    int n_fail = 0;
    int vcnt = 0;

    typedef struct {
        logic        mode;
        logic [3:0]  key;
        logic        err;
        logic [2:0]  ptr;
        logic [23:0] bcd;
        logic        done;
    } vec_t;

    vec_t vecs [NV];

    always #5 clk = ~clk;

    assign row = force_on ? force_val :
                 (kp_on && (col[kp_c] == 1'b0)) ? ~(4'b0001 << kp_r) : 4'hF;

    keypad_time_entry #(.SCAN_DIV(SCAN_DIV), .DEB_SLOTS(DEB_SLOTS)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .row(row), .col(col),
        .h1(h1), .h0(h0), .m1(m1), .m0(m0), .s1(s1), .s0(s0),
        .key_valid(key_valid), .key_code(key_code), .key_err(key_err),
        .digit_ptr(digit_ptr), .done(done)
    );

    always @(negedge clk) if (key_valid) vcnt++;

    function automatic vec_t mk(input logic m, input logic [3:0] k, input logic e,
                                input logic [2:0] p, input logic [23:0] b, input logic d);
        vec_t v;
        v.mode = m; v.key = k; v.err = e; v.ptr = p; v.bcd = b; v.done = d;
        return v;
    endfunction

    function automatic logic [23:0] bcd_now();
        return {h1, h0, m1, m0, s1, s0};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_key(input logic [3:0] code);
        case (code)
            4'd1:  begin kp_r = 2'd0; kp_c = 2'd0; end
            4'd2:  begin kp_r = 2'd0; kp_c = 2'd1; end
            4'd3:  begin kp_r = 2'd0; kp_c = 2'd2; end
            4'd10: begin kp_r = 2'd0; kp_c = 2'd3; end
            4'd4:  begin kp_r = 2'd1; kp_c = 2'd0; end
            4'd5:  begin kp_r = 2'd1; kp_c = 2'd1; end
            4'd6:  begin kp_r = 2'd1; kp_c = 2'd2; end
            4'd11: begin kp_r = 2'd1; kp_c = 2'd3; end
            4'd7:  begin kp_r = 2'd2; kp_c = 2'd0; end
            4'd8:  begin kp_r = 2'd2; kp_c = 2'd1; end
            4'd9:  begin kp_r = 2'd2; kp_c = 2'd2; end
            4'd12: begin kp_r = 2'd2; kp_c = 2'd3; end
            4'd14: begin kp_r = 2'd3; kp_c = 2'd0; end
            4'd0:  begin kp_r = 2'd3; kp_c = 2'd1; end
            4'd15: begin kp_r = 2'd3; kp_c = 2'd2; end
            default: begin kp_r = 2'd3; kp_c = 2'd3; end
        endcase
    endtask

    task automatic wait_col(input logic [3:0] target, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (col == target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_event(output logic got, output logic [3:0] kc, output logic ke);
        got = 1'b0; kc = '0; ke = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (key_valid) begin
                got = 1'b1; kc = key_code; ke = key_err;
                break;
            end
        end
    endtask

    initial begin
        logic       got, ke, ok;
        logic [3:0] kc;
        int         v0;

        vecs[0]  = mk(1, 4'd1,  0, 1, 24'h100000, 0);
        vecs[1]  = mk(1, 4'd2,  0, 2, 24'h120000, 0);
        vecs[2]  = mk(1, 4'd3,  0, 3, 24'h123000, 0);
        vecs[3]  = mk(1, 4'd4,  0, 4, 24'h123400, 0);
        vecs[4]  = mk(1, 4'd5,  0, 5, 24'h123450, 0);
        vecs[5]  = mk(1, 4'd6,  0, 6, 24'h123456, 1);
        vecs[6]  = mk(1, 4'd7,  1, 6, 24'h123456, 1);
        vecs[7]  = mk(1, 4'd14, 0, 0, 24'h000000, 0);
        vecs[8]  = mk(1, 4'd3,  1, 0, 24'h000000, 0);
        vecs[9]  = mk(1, 4'd2,  0, 1, 24'h200000, 0);
        vecs[10] = mk(1, 4'd4,  1, 1, 24'h200000, 0);
        vecs[11] = mk(1, 4'd3,  0, 2, 24'h230000, 0);
        vecs[12] = mk(1, 4'd10, 0, 2, 24'h230000, 0);
        vecs[13] = mk(1, 4'd14, 0, 0, 24'h000000, 0);
        vecs[14] = mk(1, 4'd1,  0, 1, 24'h100000, 0);
        vecs[15] = mk(1, 4'd2,  0, 2, 24'h120000, 0);
        vecs[16] = mk(1, 4'd5,  0, 3, 24'h125000, 0);
        vecs[17] = mk(1, 4'd15, 0, 2, 24'h120000, 0);
        vecs[18] = mk(1, 4'd14, 0, 0, 24'h000000, 0);
        vecs[19] = mk(1, 4'd15, 0, 0, 24'h000000, 0);
        vecs[20] = mk(1, 4'd1,  0, 1, 24'h100000, 0);
        vecs[21] = mk(1, 4'd9,  0, 2, 24'h190000, 0);
        vecs[22] = mk(1, 4'd6,  1, 2, 24'h190000, 0);
        vecs[23] = mk(1, 4'd0,  0, 3, 24'h190000, 0);
        vecs[24] = mk(0, 4'd5,  0, 1, 24'h005000, 0);
        vecs[25] = mk(0, 4'd9,  0, 2, 24'h005900, 0);
        vecs[26] = mk(0, 4'd5,  0, 3, 24'h005950, 0);
        vecs[27] = mk(0, 4'd9,  0, 4, 24'h005959, 1);
        vecs[28] = mk(0, 4'd1,  1, 4, 24'h005959, 1);
        vecs[29] = mk(0, 4'd13, 0, 4, 24'h005959, 1);
        vecs[30] = mk(0, 4'd15, 0, 3, 24'h005950, 0);
        vecs[31] = mk(0, 4'd15, 0, 2, 24'h005900, 0);
        vecs[32] = mk(0, 4'd6,  1, 2, 24'h005900, 0);
        vecs[33] = mk(0, 4'd11, 0, 2, 24'h005900, 0);

        rst = 1'b1; en = 1'b0; mode = 1'b1;
        kp_on = 1'b0; kp_r = '0; kp_c = '0; force_on = 1'b0; force_val = 4'hF;

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        check("rst_col", col, 4'hF);
        check("rst_bcd", bcd_now(), 0);
        check("rst_ptr", digit_ptr, 0);
        check("rst_code", key_code, 0);
        check("rst_valid", key_valid, 0);
        check("rst_err", key_err, 0);
        check("rst_done", done, 0);

        rst = 1'b0;
        @(negedge clk);
        check("idle_col", col, 4'hF);
        en = 1'b1;
        @(negedge clk);
        check("scan_start_col", col, 4'b1110);

        // Single-sample glitch on row2 while column 1 is driven.
        wait_col(4'b1110, ok); check("glitch_sync0", ok, 1);
        wait_col(4'b1101, ok); check("glitch_sync1", ok, 1);
        v0 = vcnt;
        force_on = 1'b1; force_val = 4'b1011;
        repeat (4) @(negedge clk);
        force_on = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (col != 4'b1101) begin ok = 1'b1; break; end
        end
        check("glitch_left_col", ok, 1);
        check("glitch_next_col", col, 4'b1011);
        repeat (20) @(negedge clk);
        check("glitch_no_event", vcnt - v0, 0);

        // Table of key presses.
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].mode != mode) begin
                mode = vecs[i].mode;
                repeat (3) @(negedge clk);
                check("mode_clr_ptr", digit_ptr, 0);
                check("mode_clr_bcd", bcd_now(), 0);
            end
            v0 = vcnt;
            set_key(vecs[i].key);
            kp_on = 1'b1;
            wait_event(got, kc, ke);
            check($sformatf("v%0d_event", i), got, 1);
            check($sformatf("v%0d_code", i), kc, vecs[i].key);
            check($sformatf("v%0d_err", i), ke, vecs[i].err);
            check($sformatf("v%0d_ptr", i), digit_ptr, vecs[i].ptr);
            check($sformatf("v%0d_bcd", i), bcd_now(), vecs[i].bcd);
            check($sformatf("v%0d_done", i), done, vecs[i].done);
            @(negedge clk);
            check($sformatf("v%0d_pulse", i), key_valid, 0);
            repeat (30) @(negedge clk);
            check($sformatf("v%0d_held_once", i), vcnt - v0, 1);
            kp_on = 1'b0;
            repeat (40) @(negedge clk);
            check($sformatf("v%0d_count", i), vcnt - v0, 1);
        end

        // en low retains the buffer; en rising clears it.
        en = 1'b0;
        repeat (3) @(negedge clk);
        check("en_off_col", col, 4'hF);
        check("en_off_ptr", digit_ptr, 2);
        check("en_off_bcd", bcd_now(), 24'h005900);
        en = 1'b1;
        @(negedge clk);
        check("en_rise_ptr", digit_ptr, 0);
        check("en_rise_bcd", bcd_now(), 0);

        // Reset while a press on key 5 is in debounce.
        wait_col(4'b1110, ok); check("rdeb_sync0", ok, 1);
        wait_col(4'b1101, ok); check("rdeb_sync1", ok, 1);
        set_key(4'd5);
        kp_on = 1'b1;
        repeat (5) @(negedge clk);
        check("rdeb_no_event_yet", key_valid, 0);
        rst = 1'b1;
        #1;
        check("rdeb_col", col, 4'hF);
        check("rdeb_ptr", digit_ptr, 0);
        check("rdeb_code", key_code, 0);
        check("rdeb_done", done, 0);
        check("rdeb_err", key_err, 0);
        repeat (2) @(negedge clk);
        v0 = vcnt;
        rst = 1'b0;
        @(negedge clk);
        check("rdeb_restart_col", col, 4'b1110);
        wait_event(got, kc, ke);
        check("rdeb_event", got, 1);
        check("rdeb_event_code", kc, 4'd5);
        check("rdeb_event_err", ke, 0);
        kp_on = 1'b0;
        repeat (40) @(negedge clk);
        check("rdeb_one_event", vcnt - v0, 1);
        check("rdeb_ptr_after", digit_ptr, 1);
        check("rdeb_bcd_after", bcd_now(), 24'h005000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_time_entry.md
KEYPAD_TIME_ENTRY -- requirements
Module: keypad_time_entry

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clk cycles per column slot (1 ms at 100 MHz).
REQ-002 SHALL have parameter DEB_SLOTS, default 5, consecutive matching column slots required to accept a press or a release.
REQ-003 SHALL have port clk  in  1  system clock; one clock only.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  in  1  entry enable.
REQ-006 SHALL have port mode  in  1  entry mode: 1 = 6 digits hh:mm:ss, 0 = 4 digits mm:ss.
REQ-007 SHALL have port row  in  4  keypad rows, active-low, externally pulled up.
REQ-008 SHALL have port col  out  4  keypad column drive, active-low, at most one bit low.
REQ-009 SHALL have ports h1,h0,m1,m0,s1,s0  out  4 each  BCD entry buffer.
REQ-010 SHALL have port key_valid  out  1  one-cycle pulse per accepted key event.
REQ-011 SHALL have port key_code  out  4  code of the last key event.
REQ-012 SHALL have port key_err  out  1  one-cycle pulse, coincident with key_valid, when a digit is rejected.
REQ-013 SHALL have port digit_ptr  out  3  number of digits entered.
REQ-014 SHALL have port done  out  1  level, high while digit_ptr equals the mode digit count (6 or 4).

Function
REQ-015 SHALL synchronise row through two flops before any use.
REQ-016 SHALL use key map (row r, col c): r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D. Codes: digits 0-9 = own value; A-D = 10-13; * = 14; # = 15.
REQ-017 SHALL run scanner FSM states IDLE, SCAN, DEBOUNCE, HELD, RELEASE.
REQ-018 IDLE: col = 4'hF. Entered whenever en = 0, from any state. en = 1 -> SCAN with col0 driven low.
REQ-019 SCAN: the driven column advances 0->1->2->3->0 every SCAN_DIV cycles. Row is sampled on the last cycle of each slot. A sampled row != 4'hF latches the row and column and goes to DEBOUNCE.
REQ-020 Multiple rows low SHALL resolve to the lowest row index.
REQ-021 DEBOUNCE: the column is held. The same row pattern for DEB_SLOTS consecutive samples (the first sample counts) -> HELD. Any differing sample -> SCAN at the next column.
REQ-022 Entry into HELD SHALL pulse key_valid for exactly one cycle, update key_code and apply the key action, all on the same cycle.
REQ-023 HELD: row = 4'hF for DEB_SLOTS consecutive samples -> RELEASE -> SCAN next cycle; a held key never produces a second event.
REQ-024 Digit action, mode 1: the buffer fills h1,h0,m1,m0,s1,s0 in order at digit_ptr, then digit_ptr increments.
REQ-025 Digit action, mode 0: the buffer fills m1,m0,s1,s0 in order; h1 and h0 stay 0.
REQ-026 Digit range rules: h1 <= 2; h0 <= 3 if h1 = 2, else <= 9; m1 <= 5; s1 <= 5.
REQ-027 A violating digit SHALL pulse key_err and leave buffer and ptr unchanged.
REQ-028 A digit with done = 1 SHALL pulse key_err and leave buffer and ptr unchanged.
REQ-029 * SHALL clear all digits to 0 and set ptr to 0.
REQ-030 # with ptr > 0 SHALL decrement ptr and zero the digit at the new ptr. # with ptr = 0 SHALL have no effect and no error.
REQ-031 A-D SHALL pulse key_valid only.
REQ-032 A rising edge of en, or any change of mode, SHALL clear buffer and ptr on the following cycle.
REQ-033 en falling SHALL retain buffer and ptr.

Reset
REQ-034 rst asserted SHALL immediately force col = 4'hF, all digits 0, digit_ptr 0, key_code 0, key_valid/key_err/done 0, FSM IDLE, and clear counters and synchronisers.
REQ-035 Reset mid-debounce or mid-held SHALL discard the pending key with no event after release.

Structure
REQ-036 Shared package kte_pkg SHALL hold the key-code constants, the scanner state enum and the digit-slot indices.
REQ-037 Scanning and debounce SHALL be sub-module keypad_scanner (outputs col, key_valid, key_code). The parent SHALL hold the BCD buffer, validation and ptr.

Verification (SCAN_DIV=4, DEB_SLOTS=2)
REQ-038 mode=1, en=1, press/release 1,2,3,4,5,6 -> six key_valid pulses; buffer 12:34:56; done=1.
REQ-039 mode=1: press 3 -> key_err, ptr 0. Press 2 then 4 -> key_err on 4, ptr 1. Press 3 -> h=23, ptr 2.
REQ-040 row2 low for 1 sample then high -> no key_valid; scanning continues at the next column.
REQ-041 Enter 1,2,5 then # -> ptr 2, m1=0. Then * -> all 0, ptr 0, done 0.
REQ-042 mode=0: enter 5,9,5,9 -> m=59, s=59, h=00, done=1. Fifth digit 1 -> key_err, buffer unchanged.
REQ-043 rst during DEBOUNCE -> col=4'hF and outputs at reset values. After release, with the key still held, the scan restarts at col=4'b1110 and yields exactly one event.
